// File: rtl/pcie_egress_arbiter_pkg.sv
// Shared definitions for the PCIe egress arbiter: TLP command encodings,
// requester index assignments, arbiter state encoding and the tag helper.
package pcie_egress_arbiter_pkg;

    // TLP fmt/type bytes as presented to the egress engine
    localparam logic [7:0] PCIE_MRD_64B = 8'h20;
    localparam logic [7:0] PCIE_MWR_64B = 8'h60;
    localparam logic [7:0] PCIE_CPLD    = 8'h4A;

    // Requester slots on the i_req / descriptor buses
    localparam int REQ_CPL = 0;
    localparam int REQ_MWR = 1;
    localparam int REQ_MRD = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // Only memory reads consume a tag; everything else goes out with tag 0
    function automatic logic [7:0] tag_for(input logic [7:0] cmd, input logic [7:0] cnt);
        return (cmd == PCIE_MRD_64B) ? cnt : 8'h00;
    endfunction

endpackage

// File: rtl/pcie_egress_arbiter_if.sv
// Handshake and descriptor bundle between the arbiter and the egress TLP engine.
// master = arbiter side, slave = engine side.
interface pcie_egress_arbiter_if;
    logic        egr_enable;
    logic        egr_finished;
    logic [7:0]  egr_command;
    logic [13:0] egr_flags;
    logic [63:0] egr_address;
    logic [15:0] egr_requester_id;
    logic [7:0]  egr_tag;
    logic [9:0]  egr_req_dword_cnt;

    modport master (
        output egr_enable,
        output egr_command,
        output egr_flags,
        output egr_address,
        output egr_requester_id,
        output egr_tag,
        output egr_req_dword_cnt,
        input  egr_finished
    );

    modport slave (
        input  egr_enable,
        input  egr_command,
        input  egr_flags,
        input  egr_address,
        input  egr_requester_id,
        input  egr_tag,
        input  egr_req_dword_cnt,
        output egr_finished
    );
endinterface

// File: rtl/pcie_egress_arbiter_rr.sv
// Combinational round-robin picker: scans requesters starting just after the
// last granted index and returns the first one found as a one-hot winner.
module pcie_rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_valid
);

    // First pending requester in rotation order after i_last_ptr wins
    always_comb begin
        int idx;
        idx     = 0;
        o_grant = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(i_last_ptr) + 1 + i) % NUM_REQ;
            if (!o_valid && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_egress_arbiter.sv
// Shares the PCIe egress TLP engine between NUM_REQ requesters
// (0 = completion, 1 = memory write, 2 = memory read).
// Optional watchdog: define PCIE_EGRESS_ARB_TIMEOUT_EN to abort a BUSY
// transaction after TIMEOUT_CYCLES without engine finished.
//
// state | meaning
// IDLE  | engine free, arbitrate among pending requesters
// BUSY  | engine enabled with the owner's descriptor, waiting for finished
// DRAIN | enable dropped, waiting for finished to fall before releasing grant
module pcie_egress_arbiter
    import pcie_egress_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           i_requester_id,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [8*NUM_REQ-1:0]  i_command,
    input  logic [14*NUM_REQ-1:0] i_flags,
    input  logic [64*NUM_REQ-1:0] i_address,
    input  logic [10*NUM_REQ-1:0] i_dword_cnt,
    output logic [NUM_REQ-1:0]    o_grant,
    output logic [NUM_REQ-1:0]    o_done,
    output logic [NUM_REQ-1:0]    o_err,
    pcie_egress_arbiter_if.master egr,
    output logic [1:0]            o_state
);

    arb_state_e           state;
    logic [IDX_W-1:0]     last_ptr;
    logic [IDX_W-1:0]     own_idx;
    logic [7:0]           tag_cnt;
    logic [NUM_REQ-1:0]   win_oh;
    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;
    logic [7:0]           win_cmd;
    logic [13:0]          win_flags;
    logic [63:0]          win_addr;
    logic [9:0]           win_dwc;
`ifdef PCIE_EGRESS_ARB_TIMEOUT_EN
    logic [15:0]          to_cnt;
    logic [NUM_REQ-1:0]   err_q;
`endif

    pcie_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req      (i_req),
        .i_last_ptr (last_ptr),
        .o_grant    (win_oh),
        .o_valid    (win_valid)
    );

    // One-hot winner to index, then select the winner's descriptor slices
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = IDX_W'(i);
        end
        win_cmd   = i_command[8*win_idx +: 8];
        win_flags = i_flags[14*win_idx +: 14];
        win_addr  = i_address[64*win_idx +: 64];
        win_dwc   = i_dword_cnt[10*win_idx +: 10];
    end

    // Arbitration / engine handshake FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= ST_IDLE;
            last_ptr              <= IDX_W'(NUM_REQ - 1);
            own_idx               <= '0;
            tag_cnt               <= 8'h00;
            o_grant               <= '0;
            o_done                <= '0;
            egr.egr_enable        <= 1'b0;
            egr.egr_command       <= '0;
            egr.egr_flags         <= '0;
            egr.egr_address       <= '0;
            egr.egr_requester_id  <= '0;
            egr.egr_tag           <= '0;
            egr.egr_req_dword_cnt <= '0;
`ifdef PCIE_EGRESS_ARB_TIMEOUT_EN
            to_cnt                <= '0;
            err_q                 <= '0;
`endif
        end else begin
            o_done <= '0;
`ifdef PCIE_EGRESS_ARB_TIMEOUT_EN
            err_q  <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        o_grant               <= win_oh;
                        own_idx               <= win_idx;
                        egr.egr_enable        <= 1'b1;
                        egr.egr_command       <= win_cmd;
                        egr.egr_flags         <= win_flags;
                        egr.egr_address       <= win_addr;
                        egr.egr_requester_id  <= i_requester_id;
                        egr.egr_req_dword_cnt <= win_dwc;
                        egr.egr_tag           <= tag_for(win_cmd, tag_cnt);
                        if (win_cmd == PCIE_MRD_64B) tag_cnt <= tag_cnt + 8'h01;
`ifdef PCIE_EGRESS_ARB_TIMEOUT_EN
                        to_cnt                <= '0;
`endif
                        state                 <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (egr.egr_finished) begin
                        egr.egr_enable <= 1'b0;
                        o_done         <= o_grant;
                        state          <= ST_DRAIN;
                    end
`ifdef PCIE_EGRESS_ARB_TIMEOUT_EN
                    else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        egr.egr_enable <= 1'b0;
                        o_done         <= o_grant;
                        err_q          <= o_grant;
                        state          <= ST_DRAIN;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                ST_DRAIN: begin
                    // Engine must be seen idle before the grant is released
                    if (!egr.egr_finished) begin
                        o_grant  <= '0;
                        last_ptr <= own_idx;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_state = state;

`ifdef PCIE_EGRESS_ARB_TIMEOUT_EN
    assign o_err = err_q;
`else
    assign o_err = '0;
`endif

endmodule

// File: tb/tb_pcie_egress_arbiter.sv
// Self-checking bench for pcie_egress_arbiter: directed vector table,
// hand-written corner sequences and randomized transactions against a
// transaction-level round-robin / tag model.
module tb_pcie_egress_arbiter;
    import pcie_egress_arbiter_pkg::*;

    localparam int N = 3;
`ifdef PCIE_EGRESS_ARB_TIMEOUT_EN
    localparam int TO        = 16;
    localparam int BUSY_LONG = 12;
`else
    localparam int TO        = 4096;
    localparam int BUSY_LONG = 20;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   i_requester_id = '0;
    logic [N-1:0]  i_req = '0;
    logic [8*N-1:0]  i_command = '0;
    logic [14*N-1:0] i_flags = '0;
    logic [64*N-1:0] i_address = '0;
    logic [10*N-1:0] i_dword_cnt = '0;
    logic [N-1:0]  o_grant, o_done, o_err;
    logic [1:0]    o_state;

    pcie_egress_arbiter_if egr_if();

    pcie_egress_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_requester_id (i_requester_id),
        .i_req          (i_req),
        .i_command      (i_command),
        .i_flags        (i_flags),
        .i_address      (i_address),
        .i_dword_cnt    (i_dword_cnt),
        .o_grant        (o_grant),
        .o_done         (o_done),
        .o_err          (o_err),
        .egr            (egr_if),
        .o_state        (o_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Descriptor sources per requester
    logic [7:0]  cmd_a [N];
    logic [13:0] flg_a [N];
    logic [63:0] adr_a [N];
    logic [9:0]  dwc_a [N];

    // Expected latched descriptor of the current transaction
    logic [7:0]  e_cmd;
    logic [13:0] e_flg;
    logic [63:0] e_adr;
    logic [9:0]  e_dwc;
    logic [15:0] e_rid;
    logic [7:0]  e_tag;

    // Reference model state: last served requester and next read tag
    int          m_ptr;
    logic [7:0]  m_tag;

    typedef struct {
        logic [2:0]  req;
        int          busy;
        int          exp_w;
        logic [7:0]  exp_tag;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_desc();
        for (int k = 0; k < N; k++) begin
            i_command[8*k +: 8]    = cmd_a[k];
            i_flags[14*k +: 14]    = flg_a[k];
            i_address[64*k +: 64]  = adr_a[k];
            i_dword_cnt[10*k +: 10] = dwc_a[k];
        end
    endtask

    task automatic rand_desc();
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
                0: cmd_a[k] = PCIE_CPLD;
                1: cmd_a[k] = PCIE_MWR_64B;
                2: cmd_a[k] = PCIE_MRD_64B;
                default: cmd_a[k] = 8'($urandom);
            endcase
            flg_a[k] = 14'($urandom);
            adr_a[k] = {$urandom, $urandom};
            dwc_a[k] = 10'($urandom);
        end
        i_requester_id = 16'($urandom);
    endtask

    task automatic fixed_desc();
        cmd_a[0] = PCIE_CPLD;
        cmd_a[1] = PCIE_MWR_64B;
        cmd_a[2] = PCIE_MRD_64B;
        for (int k = 0; k < N; k++) begin
            flg_a[k] = 14'h0100 + 14'(k);
            adr_a[k] = 64'hFEED_0000_0000_1000 + 64'(k * 64'h40);
            dwc_a[k] = 10'h010 + 10'(k);
        end
        i_requester_id = 16'hA5C3;
    endtask

    // Round-robin rule: first requester found scanning from last+1
    function automatic int predict(input logic [2:0] req, input int ptr);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_tag(input int w);
        return (w >= 0 && cmd_a[w] == PCIE_MRD_64B) ? m_tag : 8'h00;
    endfunction

    task automatic chk_held(input string name);
        chk({name, "_cmd"},  egr_if.egr_command,       e_cmd);
        chk({name, "_flg"},  egr_if.egr_flags,         e_flg);
        chk({name, "_adr"},  egr_if.egr_address,       e_adr);
        chk({name, "_rid"},  egr_if.egr_requester_id,  e_rid);
        chk({name, "_tag"},  egr_if.egr_tag,           e_tag);
        chk({name, "_dwc"},  egr_if.egr_req_dword_cnt, e_dwc);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_grant"}, o_grant, 0);
        chk({name, "_done"},  o_done, 0);
        chk({name, "_err"},   o_err, 0);
        chk({name, "_en"},    egr_if.egr_enable, 0);
        chk({name, "_cmd"},   egr_if.egr_command, 0);
        chk({name, "_flg"},   egr_if.egr_flags, 0);
        chk({name, "_adr"},   egr_if.egr_address, 0);
        chk({name, "_rid"},   egr_if.egr_requester_id, 0);
        chk({name, "_tag"},   egr_if.egr_tag, 0);
        chk({name, "_dwc"},   egr_if.egr_req_dword_cnt, 0);
        chk({name, "_state"}, o_state, 0);
    endtask

    // One full transaction from IDLE back to IDLE with cycle-exact checks
    task automatic run_txn(input logic [2:0] req, input int exp_w, input logic [7:0] exp_tag,
                           input int busy_len, input int hold, input bit perturb,
                           input logic [2:0] busy_req);
        logic [63:0] g;
        chk("idle_en", egr_if.egr_enable, 0);
        chk("idle_state", o_state, 0);
        i_req = req;
        drive_desc();
        step();
        if (exp_w < 0) begin
            chk("nogrant", o_grant, 0);
            chk("nogrant_state", o_state, 0);
            return;
        end
        g     = 64'd1 << exp_w;
        e_cmd = cmd_a[exp_w];
        e_flg = flg_a[exp_w];
        e_adr = adr_a[exp_w];
        e_dwc = dwc_a[exp_w];
        e_rid = i_requester_id;
        e_tag = exp_tag;
        chk("grant", o_grant, g);
        chk("grant_en", egr_if.egr_enable, 1);
        chk("grant_state", o_state, 1);
        chk_held("grant");
        if (perturb) begin
            i_req = busy_req;
            rand_desc();
            drive_desc();
        end
        for (int b = 0; b < busy_len; b++) begin
            step();
            chk("busy_en", egr_if.egr_enable, 1);
            chk("busy_done", o_done, 0);
            chk("busy_grant", o_grant, g);
            chk("busy_state", o_state, 1);
            chk_held("busy");
        end
        egr_if.egr_finished = 1'b1;
        step();
        chk("fin_en", egr_if.egr_enable, 0);
        chk("fin_done", o_done, g);
        chk("fin_err", o_err, 0);
        chk("fin_grant", o_grant, g);
        chk("fin_state", o_state, 2);
        chk_held("fin");
        for (int h = 0; h < hold; h++) begin
            step();
            chk("drain_done", o_done, 0);
            chk("drain_grant", o_grant, g);
            chk("drain_state", o_state, 2);
        end
        egr_if.egr_finished = 1'b0;
        step();
        chk("rel_grant", o_grant, 0);
        chk("rel_done", o_done, 0);
        chk("rel_state", o_state, 0);
        m_ptr = exp_w;
        if (e_cmd == PCIE_MRD_64B) m_tag = m_tag + 8'h01;
    endtask

    initial begin
        int w;
        logic [2:0] rq;
        egr_if.egr_finished = 1'b0;
        m_ptr = N - 1;
        m_tag = 8'h00;

        tbl[0]  = '{3'b111, 2,         0, 8'h00};
        tbl[1]  = '{3'b111, 2,         1, 8'h00};
        tbl[2]  = '{3'b111, 2,         2, 8'h00};
        tbl[3]  = '{3'b111, 1,         0, 8'h00};
        tbl[4]  = '{3'b111, 1,         1, 8'h00};
        tbl[5]  = '{3'b111, 1,         2, 8'h01};
        tbl[6]  = '{3'b010, BUSY_LONG, 1, 8'h00};
        tbl[7]  = '{3'b101, 0,         2, 8'h02};
        tbl[8]  = '{3'b101, 3,         0, 8'h00};
        tbl[9]  = '{3'b001, 0,         0, 8'h00};
        tbl[10] = '{3'b110, 2,         1, 8'h00};
        tbl[11] = '{3'b011, 0,         0, 8'h00};
        tbl[12] = '{3'b000, 0,        -1, 8'h00};

        // Reset values
        fixed_desc();
        drive_desc();
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Directed table
        for (int v = 0; v < 13; v++) begin
            run_txn(tbl[v].req, tbl[v].exp_w, tbl[v].exp_tag, tbl[v].busy, v % 3, 1'b0, 3'b000);
        end

        // Requester 0 pending but ungranted, drops before next arbitration
        fixed_desc();
        w = predict(3'b011, m_ptr);
        run_txn(3'b011, w, model_tag(w), 3, 0, 1'b1, 3'b010);
        w = predict(3'b010, m_ptr);
        run_txn(3'b010, w, model_tag(w), 1, 0, 1'b0, 3'b000);
        chk("ungranted_drop_winner", w, 1);

        // Requester 0 drops while granted: descriptor held, done still pulses
        fixed_desc();
        w = predict(3'b001, m_ptr);
        run_txn(3'b001, w, model_tag(w), 4, 1, 1'b1, 3'b000);

        // Asynchronous reset in the middle of BUSY
        fixed_desc();
        i_req = 3'b111;
        drive_desc();
        w = predict(3'b111, m_ptr);
        step();
        chk("prerst_grant", o_grant, 64'd1 << w);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        chk_all_zero("held_rst");
        rst_n = 1'b1;
        m_ptr = N - 1;
        m_tag = 8'h00;
        run_txn(3'b111, 0, 8'h00, 1, 0, 1'b0, 3'b000);

        // 257 reads from requester 2: tags 00..FF then wrap to 00
        fixed_desc();
        for (int t = 0; t < 257; t++) begin
            dwc_a[2] = 10'($urandom);
            adr_a[2] = {$urandom, $urandom};
            run_txn(3'b100, 2, 8'(t), 0, 0, 1'b0, 3'b000);
        end

`ifdef PCIE_EGRESS_ARB_TIMEOUT_EN
        // Watchdog abort: finished never raised
        begin
            int cyc;
            bit seen;
            fixed_desc();
            i_req = 3'b001;
            drive_desc();
            w = predict(3'b001, m_ptr);
            step();
            chk("to_grant", o_grant, 64'd1 << w);
            cyc = 0;
            seen = 1'b0;
            for (int c = 0; c < 4 * TO && !seen; c++) begin
                step();
                cyc++;
                if (o_done != 0) seen = 1'b1;
            end
            chk("to_seen", seen, 1);
            chk("to_cycles", cyc, TO);
            chk("to_done", o_done, 64'd1 << w);
            chk("to_err", o_err, 64'd1 << w);
            chk("to_en", egr_if.egr_enable, 0);
            chk("to_state", o_state, 2);
            step();
            chk("to_idle_state", o_state, 0);
            chk("to_idle_grant", o_grant, 0);
            m_ptr = w;
        end
`else
        // Without the watchdog a long BUSY never self-terminates
        fixed_desc();
        w = predict(3'b001, m_ptr);
        run_txn(3'b001, w, model_tag(w), 150, 0, 1'b0, 3'b000);
`endif

        // Randomized transactions against the model
        for (int r = 0; r < 300; r++) begin
            rand_desc();
            rq = 3'($urandom);
            w  = predict(rq, m_ptr);
            run_txn(rq, w, model_tag(w), $urandom_range(0, 8), $urandom_range(0, 2),
                    1'($urandom), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
